// File: rtl/cpu_stack_ctrl.sv
// rtl/cpu_stack_ctrl.sv - command sequencer and depth tracker for the 8-level CPU address stack
module cpu_stack_ctrl #(
    parameter int LEVELS = 8,
    parameter int PTR_W  = 3,
    parameter int STRICT = 0
) (
    input  logic             CLK_I,
    input  logic             nRST_I,
    input  logic             CMD_VALID_I,
    output logic             CMD_READY_O,
    input  logic [2:0]       CMD_I,
    input  logic [13:0]      ADDR_I,
    output logic             DONE_O,
    output logic             ERR_O,
    output logic [13:0]      PC_O,
    output logic [PTR_W-1:0] DEPTH_O,
    output logic             OVF_O,
    output logic             UNF_O,
    input  logic             CLR_ERR_I,
    output logic             STK_RD_O,
    output logic             STK_WR_O,
    output logic             STK_HA_O,
    output logic             STK_INCR_O,
    output logic             STK_PUSH_O,
    output logic             STK_POP_O,
    output logic [7:0]       STK_DAT_O,
    input  logic [7:0]       STK_DAT_I
);

    localparam logic [2:0] LP_NOP  = 3'd0;
    localparam logic [2:0] LP_INC  = 3'd1;
    localparam logic [2:0] LP_JMP  = 3'd2;
    localparam logic [2:0] LP_CALL = 3'd3;
    localparam logic [2:0] LP_RET  = 3'd4;
    localparam logic [2:0] LP_RST  = 3'd5;
    localparam logic [2:0] LP_RDPC = 3'd6;

    localparam logic [PTR_W-1:0] LP_TOP = PTR_W'(LEVELS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_INC  = 3'd1,
        S_PUSH = 3'd2,
        S_WRL  = 3'd3,
        S_WRH  = 3'd4,
        S_POP  = 3'd5,
        S_RDL  = 3'd6,
        S_RDH  = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_done_set;
    logic             w_err_set;
    logic             w_accept;
    logic             w_full;
    logic             w_empty;
    logic             w_is_push_cmd;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic [7:0]       w_wr_lo;
    logic [7:0]       w_wr_hi;
    logic [7:0]       r_wr_lo;
    logic [7:0]       r_wr_hi;
    logic             r_done;
    logic             r_err;
    logic [13:0]      r_pc;
    logic [PTR_W-1:0] r_depth;
    logic             r_ovf;
    logic             r_unf;
    logic [1:0]       w_unused_dat;

    assign w_unused_dat  = STK_DAT_I[7:6];
    assign w_accept      = CMD_VALID_I && (r_state == IDLE);
    assign w_full        = (r_depth == LP_TOP);
    assign w_empty       = (r_depth == '0);
    assign w_is_push_cmd = (CMD_I == LP_CALL) || (CMD_I == LP_RST);
    assign w_ovf_set     = w_accept && w_is_push_cmd && w_full;
    assign w_unf_set     = w_accept && (CMD_I == LP_RET) && w_empty;

    // Write bytes for the two-cycle PC write: RST vectors land on n*8, others take ADDR_I
    always_comb begin
        w_wr_lo = ADDR_I[7:0];
        w_wr_hi = {2'b00, ADDR_I[13:8]};
        if (CMD_I == LP_RST) begin
            w_wr_lo = {2'b00, ADDR_I[2:0], 3'b000};
            w_wr_hi = 8'h00;
        end
    end

    // State register
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: decode the accepted command into its strobe sequence
    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        w_err_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (CMD_I)
                        LP_NOP:  w_done_set = 1'b1;
                        LP_INC:  w_next = S_INC;
                        LP_JMP:  w_next = S_WRL;
                        LP_CALL,
                        LP_RST: begin
                            if ((STRICT != 0) && w_full) begin
                                w_done_set = 1'b1;
                                w_err_set  = 1'b1;
                            end else begin
                                w_next = S_PUSH;
                            end
                        end
                        LP_RET: begin
                            if ((STRICT != 0) && w_empty) begin
                                w_done_set = 1'b1;
                                w_err_set  = 1'b1;
                            end else begin
                                w_next = S_POP;
                            end
                        end
                        LP_RDPC: w_next = S_RDL;
                        default: begin
                            w_done_set = 1'b1;
                            w_err_set  = 1'b1;
                        end
                    endcase
                end
            end
            S_PUSH: w_next = S_WRL;
            S_WRL:  w_next = S_WRH;
            S_RDL:  w_next = S_RDH;
            S_INC, S_WRH, S_POP, S_RDH: begin
                w_next     = IDLE;
                w_done_set = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    // Moore strobe decode; async reset forces IDLE so strobes drop immediately
    always_comb begin
        CMD_READY_O = 1'b0;
        STK_RD_O    = 1'b0;
        STK_WR_O    = 1'b0;
        STK_HA_O    = 1'b0;
        STK_INCR_O  = 1'b0;
        STK_PUSH_O  = 1'b0;
        STK_POP_O   = 1'b0;
        STK_DAT_O   = 8'h00;
        case (r_state)
            IDLE:   CMD_READY_O = 1'b1;
            S_INC:  STK_INCR_O  = 1'b1;
            S_PUSH: STK_PUSH_O  = 1'b1;
            S_POP:  STK_POP_O   = 1'b1;
            S_WRL: begin
                STK_WR_O  = 1'b1;
                STK_DAT_O = r_wr_lo;
            end
            S_WRH: begin
                STK_WR_O  = 1'b1;
                STK_HA_O  = 1'b1;
                STK_DAT_O = r_wr_hi;
            end
            S_RDL:  STK_RD_O = 1'b1;
            S_RDH: begin
                STK_RD_O = 1'b1;
                STK_HA_O = 1'b1;
            end
            default: CMD_READY_O = 1'b0;
        endcase
    end

    // Capture write bytes on accept so ADDR_I may change once the command is taken
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            r_wr_lo <= 8'h00;
            r_wr_hi <= 8'h00;
        end else if (w_accept) begin
            r_wr_lo <= w_wr_lo;
            r_wr_hi <= w_wr_hi;
        end
    end

    // One-cycle completion/error pulses, registered on the transition back to IDLE
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_done_set;
            r_err  <= w_err_set;
        end
    end

    // PC readback, low byte then high six bits
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            r_pc <= 14'h0000;
        end else if (r_state == S_RDL) begin
            r_pc[7:0] <= STK_DAT_I;
        end else if (r_state == S_RDH) begin
            r_pc[13:8] <= STK_DAT_I[5:0];
        end
    end

    // Depth mirror of the stack pointer, wrapping modulo LEVELS
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            r_depth <= '0;
        end else if (r_state == S_PUSH) begin
            r_depth <= w_full ? '0 : r_depth + 1'b1;
        end else if (r_state == S_POP) begin
            r_depth <= w_empty ? LP_TOP : r_depth - 1'b1;
        end
    end

    // Sticky overflow/underflow flags; a set in the same cycle beats a clear
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set || (r_ovf && !CLR_ERR_I);
            r_unf <= w_unf_set || (r_unf && !CLR_ERR_I);
        end
    end

    assign DONE_O  = r_done;
    assign ERR_O   = r_err;
    assign PC_O    = r_pc;
    assign DEPTH_O = r_depth;
    assign OVF_O   = r_ovf;
    assign UNF_O   = r_unf;

endmodule

// File: tb/tb_cpu_stack_ctrl.sv
// tb/tb_cpu_stack_ctrl.sv - directed self-checking bench for cpu_stack_ctrl
module tb_cpu_stack_ctrl;

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_INC  = 3'd1;
    localparam logic [2:0] C_JMP  = 3'd2;
    localparam logic [2:0] C_CALL = 3'd3;
    localparam logic [2:0] C_RET  = 3'd4;
    localparam logic [2:0] C_RST  = 3'd5;
    localparam logic [2:0] C_RDPC = 3'd6;
    localparam logic [2:0] C_RSV  = 3'd7;

    // strobe vector {push,pop,incr,wr,rd,ha}
    localparam logic [5:0] T_NONE = 6'b000000;
    localparam logic [5:0] T_PUSH = 6'b100000;
    localparam logic [5:0] T_POP  = 6'b010000;
    localparam logic [5:0] T_INCR = 6'b001000;
    localparam logic [5:0] T_WRL  = 6'b000100;
    localparam logic [5:0] T_WRH  = 6'b000101;
    localparam logic [5:0] T_RDL  = 6'b000010;
    localparam logic [5:0] T_RDH  = 6'b000011;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        valid, ready, done, err, ovf, unf, clr;
    logic [2:0]  cmd;
    logic [13:0] addr, pc;
    logic [2:0]  depth;
    logic        rd, wr, ha, incr, push, pop;
    logic [7:0]  dat_o, dat_i;

    logic        s_valid, s_ready, s_done, s_err, s_ovf, s_unf, s_clr;
    logic [2:0]  s_cmd;
    logic [13:0] s_addr, s_pc;
    logic [2:0]  s_depth;
    logic        s_rd, s_wr, s_ha, s_incr, s_push, s_pop;
    logic [7:0]  s_dat_o;

    cpu_stack_ctrl #(.LEVELS(8), .PTR_W(3), .STRICT(0)) u_dut (
        .CLK_I(clk), .nRST_I(rst_n), .CMD_VALID_I(valid), .CMD_READY_O(ready),
        .CMD_I(cmd), .ADDR_I(addr), .DONE_O(done), .ERR_O(err), .PC_O(pc),
        .DEPTH_O(depth), .OVF_O(ovf), .UNF_O(unf), .CLR_ERR_I(clr),
        .STK_RD_O(rd), .STK_WR_O(wr), .STK_HA_O(ha), .STK_INCR_O(incr),
        .STK_PUSH_O(push), .STK_POP_O(pop), .STK_DAT_O(dat_o), .STK_DAT_I(dat_i)
    );

    cpu_stack_ctrl #(.LEVELS(8), .PTR_W(3), .STRICT(1)) u_strict (
        .CLK_I(clk), .nRST_I(rst_n), .CMD_VALID_I(s_valid), .CMD_READY_O(s_ready),
        .CMD_I(s_cmd), .ADDR_I(s_addr), .DONE_O(s_done), .ERR_O(s_err), .PC_O(s_pc),
        .DEPTH_O(s_depth), .OVF_O(s_ovf), .UNF_O(s_unf), .CLR_ERR_I(s_clr),
        .STK_RD_O(s_rd), .STK_WR_O(s_wr), .STK_HA_O(s_ha), .STK_INCR_O(s_incr),
        .STK_PUSH_O(s_push), .STK_POP_O(s_pop), .STK_DAT_O(s_dat_o), .STK_DAT_I(8'h00)
    );

    // behavioural address stack driven by the strobes
    logic [13:0] mem [8];
    logic [2:0]  sp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp <= 3'd0;
        else if (push) sp <= sp + 3'd1;
        else if (pop) sp <= sp - 3'd1;
    end

    always @(posedge clk) begin
        if (wr && ha) mem[sp][13:8] <= dat_o[5:0];
        else if (wr) mem[sp][7:0] <= dat_o;
        else if (incr) mem[sp] <= mem[sp] + 14'd1;
    end

    assign dat_i = ha ? {2'b00, mem[sp][13:8]} : mem[sp][7:0];

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] tr_str [0:9];
    logic [7:0] tr_dat [0:9];
    int         lat;
    logic       err_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {push, pop, incr, wr, rd, ha};
    endfunction

    // issue one command on the non-strict DUT and trace cycles until DONE_O
    task automatic run_cmd(input logic [2:0] c, input logic [13:0] a);
        @(negedge clk);
        valid = 1'b1; cmd = c; addr = a;
        @(negedge clk);
        valid = 1'b0; cmd = C_NOP; addr = 14'h0;
        lat = 0; err_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tr_str[k] = T_NONE;
            tr_dat[k] = 8'h00;
        end
        for (int k = 1; k <= 8; k++) begin
            tr_str[k] = strobes();
            tr_dat[k] = dat_o;
            if (done) begin
                lat = k;
                err_seen = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    int incr_cnt;
    int done_cnt;

    initial begin
        rst_n = 1'b0; valid = 1'b0; cmd = C_NOP; addr = 14'h0; clr = 1'b0;
        s_valid = 1'b0; s_cmd = C_NOP; s_addr = 14'h0; s_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_strobes", 32'(strobes()), 32'(T_NONE));
        chk("rst_dat", 32'(dat_o), 32'h0);
        chk("rst_done_err", 32'({done, err}), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_depth", 32'(depth), 32'h0);
        chk("rst_flags", 32'({ovf, unf}), 32'h0);
        rst_n = 1'b1;

        // 1: JMP then RDPC
        run_cmd(C_JMP, 14'h2A5C);
        chk("jmp_lat", 32'(lat), 32'd3);
        chk("jmp_s1", 32'(tr_str[1]), 32'(T_WRL));
        chk("jmp_d1", 32'(tr_dat[1]), 32'h5C);
        chk("jmp_s2", 32'(tr_str[2]), 32'(T_WRH));
        chk("jmp_d2", 32'(tr_dat[2]), 32'h2A);
        chk("jmp_s3", 32'(tr_str[3]), 32'(T_NONE));
        chk("jmp_err", 32'(err_seen), 32'd0);
        run_cmd(C_RDPC, 14'h0);
        chk("rdpc1_lat", 32'(lat), 32'd3);
        chk("rdpc1_s1", 32'(tr_str[1]), 32'(T_RDL));
        chk("rdpc1_s2", 32'(tr_str[2]), 32'(T_RDH));
        chk("rdpc1_pc", 32'(pc), 32'h2A5C);

        // 2: CALL / RET / RDPC
        run_cmd(C_CALL, 14'h0100);
        chk("call_lat", 32'(lat), 32'd4);
        chk("call_s1", 32'(tr_str[1]), 32'(T_PUSH));
        chk("call_s2", 32'(tr_str[2]), 32'(T_WRL));
        chk("call_d2", 32'(tr_dat[2]), 32'h00);
        chk("call_s3", 32'(tr_str[3]), 32'(T_WRH));
        chk("call_d3", 32'(tr_dat[3]), 32'h01);
        chk("call_depth", 32'(depth), 32'd1);
        run_cmd(C_RET, 14'h0);
        chk("ret_lat", 32'(lat), 32'd2);
        chk("ret_s1", 32'(tr_str[1]), 32'(T_POP));
        chk("ret_depth", 32'(depth), 32'd0);
        run_cmd(C_RDPC, 14'h0);
        chk("rdpc2_pc", 32'(pc), 32'h2A5C);

        // 3: RST n=5
        run_cmd(C_RST, 14'h0005);
        chk("rst5_lat", 32'(lat), 32'd4);
        chk("rst5_s1", 32'(tr_str[1]), 32'(T_PUSH));
        chk("rst5_d2", 32'(tr_dat[2]), 32'h28);
        chk("rst5_s3", 32'(tr_str[3]), 32'(T_WRH));
        chk("rst5_d3", 32'(tr_dat[3]), 32'h00);
        run_cmd(C_RDPC, 14'h0);
        chk("rdpc3_pc", 32'(pc), 32'h0028);

        // 4: overflow wrap, clear, underflow
        run_cmd(C_RET, 14'h0);
        chk("pre_ovf_depth", 32'(depth), 32'd0);
        chk("pre_ovf_unf", 32'(unf), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            run_cmd(C_CALL, 14'(k * 16));
            if (k == 7) begin
                chk("call7_ovf", 32'(ovf), 32'd0);
                chk("call7_depth", 32'(depth), 32'd7);
            end
        end
        chk("call8_ovf", 32'(ovf), 32'd1);
        chk("call8_depth", 32'(depth), 32'd0);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);
        run_cmd(C_RET, 14'h0);
        chk("unf_s1", 32'(tr_str[1]), 32'(T_POP));
        chk("unf_flag", 32'(unf), 32'd1);
        chk("unf_depth", 32'(depth), 32'd7);

        // 5: back-to-back INC with VALID held, then reserved command
        incr_cnt = 0;
        @(negedge clk);
        valid = 1'b1; cmd = C_INC;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 6) begin
                valid = 1'b0; cmd = C_NOP;
            end
            chk($sformatf("inc_incr%0d", k), 32'(incr), 32'(k % 2));
            chk($sformatf("inc_ready%0d", k), 32'(ready), 32'((k + 1) % 2));
        end
        run_cmd(C_RDPC, 14'h0);
        chk("inc_pc", 32'(pc), 32'h0073);
        run_cmd(C_RSV, 14'h0);
        chk("rsv_lat", 32'(lat), 32'd1);
        chk("rsv_err", 32'(err_seen), 32'd1);
        chk("rsv_s1", 32'(tr_str[1]), 32'(T_NONE));

        // 6: reset during S_WRL of a CALL
        @(negedge clk);
        valid = 1'b1; cmd = C_CALL; addr = 14'h3FFF;
        @(negedge clk);
        valid = 1'b0; cmd = C_NOP; addr = 14'h0;
        chk("abort_push", 32'(strobes()), 32'(T_PUSH));
        @(negedge clk);
        chk("abort_wrl", 32'(strobes()), 32'(T_WRL));
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", 32'({strobes(), dat_o}), 32'h0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_depth", 32'(depth), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // STRICT=1: underflow and overflow are aborted
        @(negedge clk);
        s_valid = 1'b1; s_cmd = C_RET;
        @(negedge clk);
        s_valid = 1'b0; s_cmd = C_NOP;
        chk("strict_ret_done_err", 32'({s_done, s_err}), 32'h3);
        chk("strict_ret_pop", 32'(s_pop), 32'd0);
        chk("strict_ret_depth", 32'(s_depth), 32'd0);
        chk("strict_ret_unf", 32'(s_unf), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            s_valid = 1'b1; s_cmd = C_CALL; s_addr = 14'h0040;
            @(negedge clk);
            s_valid = 1'b0; s_cmd = C_NOP;
            for (int j = 0; j < 8 && !s_done; j++) @(negedge clk);
        end
        chk("strict_depth7", 32'(s_depth), 32'd7);
        @(negedge clk);
        s_valid = 1'b1; s_cmd = C_CALL;
        @(negedge clk);
        s_valid = 1'b0; s_cmd = C_NOP;
        chk("strict_call_done_err", 32'({s_done, s_err}), 32'h3);
        chk("strict_call_push", 32'(s_push), 32'd0);
        chk("strict_call_ovf", 32'(s_ovf), 32'd1);
        @(negedge clk);
        chk("strict_call_depth", 32'(s_depth), 32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
